// File: rtl/cube_facelet_sampler_if.sv
// Pixel-stream, window-origin and averaged-colour signals shared between
// the CCD front end, the facelet sampler and the overlay stage.
interface cube_facelet_sampler_if #(
  parameter int PIX_W = 10
);
  logic             iFrame_Start;
  logic             iDVAL;
  logic [9:0]       iX;
  logic [9:0]       iY;
  logic [PIX_W-1:0] iR;
  logic [PIX_W-1:0] iG;
  logic [PIX_W-1:0] iB;
  logic [9:0]       CubeX;
  logic [9:0]       CubeY;
  logic             iHold;
  logic [7:0]       Color_R;
  logic [7:0]       Color_G;
  logic [7:0]       Color_B;
  logic             oColor_Valid;
  logic             oSample_Err;
  logic             oBusy;

  // Sampler side: consumes the stream, produces the held colour.
  modport slave (
    input  iFrame_Start, iDVAL, iX, iY, iR, iG, iB, CubeX, CubeY, iHold,
    output Color_R, Color_G, Color_B, oColor_Valid, oSample_Err, oBusy
  );

  // Source side: drives the stream, observes the colour.
  modport master (
    output iFrame_Start, iDVAL, iX, iY, iR, iG, iB, CubeX, CubeY, iHold,
    input  Color_R, Color_G, Color_B, oColor_Valid, oSample_Err, oBusy
  );
endinterface

// File: rtl/cube_facelet_sampler.sv
// Box-filters the pixels inside a 2^LOG2_WIN square window once per frame
// and presents the truncated 8-bit mean of each colour channel. The result
// registers only change on the single update edge so the overlay never tears.
module cube_facelet_sampler #(
  parameter int LOG2_WIN = 3,
  parameter int PIX_W    = 10
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  cube_facelet_sampler_if.slave bus
);
  localparam int N     = 1 << LOG2_WIN;
  localparam int SUM_W = PIX_W + 2 * LOG2_WIN;
  localparam int CNT_W = 2 * LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N * N - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [9:0]       wx_reg, wx_next;
  logic [9:0]       wy_reg, wy_next;
  logic [SUM_W-1:0] sum_r_reg, sum_r_next;
  logic [SUM_W-1:0] sum_g_reg, sum_g_next;
  logic [SUM_W-1:0] sum_b_reg, sum_b_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [7:0]       color_r_reg, color_r_next;
  logic [7:0]       color_g_reg, color_g_next;
  logic [7:0]       color_b_reg, color_b_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;

  // Window bounds at 11 bits: a window past column/row 1023 can never fill.
  logic [10:0] x_lo, x_hi, y_lo, y_hi, px, py;
  logic        pixel_hit;

  assign x_lo = {1'b0, wx_reg};
  assign y_lo = {1'b0, wy_reg};
  assign x_hi = x_lo + 11'(N - 1);
  assign y_hi = y_lo + 11'(N - 1);
  assign px   = {1'b0, bus.iX};
  assign py   = {1'b0, bus.iY};
  assign pixel_hit = bus.iDVAL && (px >= x_lo) && (px <= x_hi) &&
                     (py >= y_lo) && (py <= y_hi);

  // State, window origin, accumulators and held result registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg   <= IDLE;
      wx_reg      <= '0;
      wy_reg      <= '0;
      sum_r_reg   <= '0;
      sum_g_reg   <= '0;
      sum_b_reg   <= '0;
      count_reg   <= '0;
      color_r_reg <= '0;
      color_g_reg <= '0;
      color_b_reg <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wx_reg      <= wx_next;
      wy_reg      <= wy_next;
      sum_r_reg   <= sum_r_next;
      sum_g_reg   <= sum_g_next;
      sum_b_reg   <= sum_b_next;
      count_reg   <= count_next;
      color_r_reg <= color_r_next;
      color_g_reg <= color_g_next;
      color_b_reg <= color_b_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic: a frame start always beats a coincident pixel, and a
  // frame start seen in DONE is dropped so that frame is skipped.
  always_comb begin
    state_next   = state_reg;
    wx_next      = wx_reg;
    wy_next      = wy_reg;
    sum_r_next   = sum_r_reg;
    sum_g_next   = sum_g_reg;
    sum_b_next   = sum_b_reg;
    count_next   = count_reg;
    color_r_next = color_r_reg;
    color_g_next = color_g_reg;
    color_b_next = color_b_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.iFrame_Start && !bus.iHold) begin
          wx_next    = bus.CubeX;
          wy_next    = bus.CubeY;
          sum_r_next = '0;
          sum_g_next = '0;
          sum_b_next = '0;
          count_next = '0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.iFrame_Start) begin
          err_next = 1'b1;
          if (!bus.iHold) begin
            wx_next    = bus.CubeX;
            wy_next    = bus.CubeY;
            sum_r_next = '0;
            sum_g_next = '0;
            sum_b_next = '0;
            count_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else if (pixel_hit) begin
          sum_r_next = sum_r_reg + SUM_W'(bus.iR);
          sum_g_next = sum_g_reg + SUM_W'(bus.iG);
          sum_b_next = sum_b_reg + SUM_W'(bus.iB);
          count_next = count_reg + 1'b1;
          if (count_reg == LAST_CNT) state_next = DONE;
        end
      end
      DONE: begin
        color_r_next = sum_r_reg[SUM_W-1 -: 8];
        color_g_next = sum_g_reg[SUM_W-1 -: 8];
        color_b_next = sum_b_reg[SUM_W-1 -: 8];
        valid_next   = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.Color_R      = color_r_reg;
  assign bus.Color_G      = color_g_reg;
  assign bus.Color_B      = color_b_reg;
  assign bus.oColor_Valid = valid_reg;
  assign bus.oSample_Err  = err_reg;
  assign bus.oBusy        = (state_reg == ACCUM);
endmodule

// File: tb/tb_cube_facelet_sampler.sv
// Directed bench for the facelet sampler: reset, uniform/mixed windows,
// incomplete window, mid-frame origin change, hold, and frame start in DONE.
module tb_cube_facelet_sampler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   vcnt = 0;
  int   ecnt = 0;

  always #5 clk = ~clk;

  cube_facelet_sampler_if #(.PIX_W(10)) ifc ();

  cube_facelet_sampler #(.LOG2_WIN(3), .PIX_W(10)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (ifc)
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.oColor_Valid === 1'b1) vcnt++;
    if (ifc.oSample_Err === 1'b1) ecnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_color(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    check({tag, "_R"}, 32'(ifc.Color_R), 32'(r));
    check({tag, "_G"}, 32'(ifc.Color_G), 32'(g));
    check({tag, "_B"}, 32'(ifc.Color_B), 32'(b));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    ifc.iFrame_Start = 1'b1;
    idle(1);
    ifc.iFrame_Start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input int r, input int g, input int b);
    ifc.iDVAL = 1'b1;
    ifc.iX = 10'(x);
    ifc.iY = 10'(y);
    ifc.iR = 10'(r);
    ifc.iG = 10'(g);
    ifc.iB = 10'(b);
    idle(1);
    ifc.iDVAL = 1'b0;
  endtask

  // Each row is preceded by an out-of-window pixel and a DVAL gap; the
  // last in-window pixel is the final thing driven.
  task automatic send_window(input int x0, input int y0, input int rl, input int rr,
                             input int g, input int b);
    for (int y = 0; y < 8; y++) begin
      pix(x0 + 8, y0 + y, 10'h3FF, 10'h3FF, 10'h3FF);
      idle(1);
      for (int x = 0; x < 8; x++) pix(x0 + x, y0 + y, (x < 4) ? rl : rr, g, b);
    end
  endtask

  initial begin
    ifc.iFrame_Start = 1'b0;
    ifc.iDVAL = 1'b0;
    ifc.iX = '0;
    ifc.iY = '0;
    ifc.iR = '0;
    ifc.iG = '0;
    ifc.iB = '0;
    ifc.CubeX = 10'd100;
    ifc.CubeY = 10'd50;
    ifc.iHold = 1'b0;

    // Reset defaults.
    idle(3);
    check("rst_valid", 32'(ifc.oColor_Valid), 0);
    check("rst_err", 32'(ifc.oSample_Err), 0);
    check("rst_busy", 32'(ifc.oBusy), 0);
    check_color("rst", 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    idle(2);

    // Asynchronous reset in the middle of accumulation.
    frame_start();
    check("busy_after_start", 32'(ifc.oBusy), 1);
    pix(100, 50, 10'h3FF, 10'h3FF, 10'h3FF);
    pix(101, 50, 10'h3FF, 10'h3FF, 10'h3FF);
    #3 rst_n = 1'b0;
    #1 check("async_rst_busy", 32'(ifc.oBusy), 0);
    #2 rst_n = 1'b1;
    idle(20);
    check("no_frame_no_valid", 32'(vcnt), 0);
    $display("tx reset: busy cleared asynchronously, no pulses");

    // Uniform frame.
    frame_start();
    send_window(100, 50, 10'h3FF, 10'h3FF, 10'h200, 10'h004);
    check("uni_valid_early", 32'(ifc.oColor_Valid), 0);
    check_color("uni_hold", 8'h00, 8'h00, 8'h00);
    idle(1);
    check("uni_valid", 32'(ifc.oColor_Valid), 1);
    check_color("uni", 8'hFF, 8'h80, 8'h01);
    idle(1);
    check("uni_valid_once", 32'(ifc.oColor_Valid), 0);
    check("uni_vcnt", 32'(vcnt), 1);
    $display("tx uniform: color=%h/%h/%h", ifc.Color_R, ifc.Color_G, ifc.Color_B);

    // Mixed window: left half R=100, right half R=300, outside pixels 3FF.
    frame_start();
    send_window(100, 50, 10'h100, 10'h300, 10'h010, 10'h3FF);
    idle(1);
    check("mix_valid", 32'(ifc.oColor_Valid), 1);
    check_color("mix", 8'h80, 8'h04, 8'hFF);
    $display("tx mixed: color=%h/%h/%h", ifc.Color_R, ifc.Color_G, ifc.Color_B);

    // Incomplete window crossing column 1023.
    ifc.CubeX = 10'd1020;
    frame_start();
    send_window(1020, 50, 10'h000, 10'h000, 10'h000, 10'h000);
    idle(3);
    check("inc_no_valid", 32'(vcnt), 2);
    ifc.CubeX = 10'd100;
    frame_start();
    check("inc_err", 32'(ifc.oSample_Err), 1);
    check("inc_busy", 32'(ifc.oBusy), 1);
    check_color("inc_keep", 8'h80, 8'h04, 8'hFF);
    $display("tx incomplete: err pulsed, color kept");

    // Origin moves to 300 after the latch; window 100 still governs.
    ifc.CubeX = 10'd300;
    pix(300, 50, 10'h3FF, 10'h3FF, 10'h3FF);
    check("inc_err_once", 32'(ifc.oSample_Err), 0);
    send_window(300, 50, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    send_window(100, 50, 10'h040, 10'h040, 10'h100, 10'h008);
    idle(1);
    check("org_valid", 32'(ifc.oColor_Valid), 1);
    check_color("org", 8'h10, 8'h40, 8'h02);
    $display("tx origin-latched: color=%h/%h/%h", ifc.Color_R, ifc.Color_G, ifc.Color_B);

    // Next frame picks up the new origin.
    frame_start();
    send_window(300, 50, 10'h200, 10'h200, 10'h200, 10'h200);
    idle(1);
    check("new_org_valid", 32'(ifc.oColor_Valid), 1);
    check_color("new_org", 8'h80, 8'h80, 8'h80);
    $display("tx new-origin: color=%h/%h/%h", ifc.Color_R, ifc.Color_G, ifc.Color_B);

    // Hold: frame start ignored, no update.
    ifc.iHold = 1'b1;
    frame_start();
    check("hold_busy", 32'(ifc.oBusy), 0);
    send_window(300, 50, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    idle(3);
    check("hold_vcnt", 32'(vcnt), 4);
    check_color("hold", 8'h80, 8'h80, 8'h80);
    $display("tx hold: no update");

    // Release hold; frame start coinciding with DONE is skipped.
    ifc.iHold = 1'b0;
    frame_start();
    send_window(300, 50, 10'h3FF, 10'h3FF, 10'h000, 10'h100);
    ifc.iFrame_Start = 1'b1;
    idle(1);
    ifc.iFrame_Start = 1'b0;
    check("done_fs_valid", 32'(ifc.oColor_Valid), 1);
    check("done_fs_busy", 32'(ifc.oBusy), 0);
    check_color("release", 8'hFF, 8'h00, 8'h40);
    idle(1);
    check("done_fs_skipped", 32'(ifc.oBusy), 0);
    idle(2);
    check("final_vcnt", 32'(vcnt), 5);
    check("final_ecnt", 32'(ecnt), 1);
    $display("tx release: color=%h/%h/%h", ifc.Color_R, ifc.Color_G, ifc.Color_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
